// File: rtl/axi2reg_pkg.sv
// Shared constants, read FSM state type and address helper for the
// AXI4-Lite to register-bus bridge.
package axi2reg_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } rd_state_t;

    // Number of byte-offset bits below the word address.
    function automatic int addr_lsb(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/axi2reg_strb_if.sv
// AXI4-Lite slave-side bundle. Handshake rule on every channel: a transfer
// happens in a cycle where both valid and ready are high at the rising edge;
// the source holds valid and payload stable until that happens.
interface axi2reg_strb_if #(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 32
);
    logic [AXI_ADDR_WIDTH-1:0] awaddr;
    logic [2:0]                awprot;
    logic                      awvalid;
    logic                      awready;
    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wvalid;
    logic                      wready;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;
    logic [AXI_ADDR_WIDTH-1:0] araddr;
    logic [2:0]                arprot;
    logic                      arvalid;
    logic                      arready;
    logic [DATA_WIDTH-1:0]     rdata;
    logic [1:0]                rresp;
    logic                      rvalid;
    logic                      rready;

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        input  araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
        output araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axi2reg_rd_ctrl.sv
// Read channel of the bridge: accepts one AR, issues a single reg_rden,
// waits out the register-file latency, captures the data and holds R.
module axi2reg_rd_ctrl
    import axi2reg_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int RD_LATENCY     = 1,
    localparam int ADDR_LSB      = addr_lsb(DATA_WIDTH),
    localparam int RA_W          = AXI_ADDR_WIDTH - ADDR_LSB
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [AXI_ADDR_WIDTH-1:0] araddr,
    input  logic                      arvalid,
    output logic                      arready,
    output logic [DATA_WIDTH-1:0]     rdata,
    output logic [1:0]                rresp,
    output logic                      rvalid,
    input  logic                      rready,
    output logic                      reg_rden,
    output logic [RA_W-1:0]           reg_rdaddr,
    input  logic [DATA_WIDTH-1:0]     reg_rddata,
    output rd_state_t                 state
);

    localparam logic [2:0] LAT = 3'(RD_LATENCY);

    logic [2:0]      cnt;
    logic            in_range_q;
    logic [RA_W-1:0] ar_word;
    logic            ar_in_range;
    logic            ar_hs;
    logic            capture;
    logic            unused_bits;

    assign ar_word     = araddr[AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign ar_in_range = int'(ar_word) < NUM_REGS;
    assign arready     = (state == IDLE);
    assign ar_hs       = arvalid && arready;
    assign unused_bits = ^araddr[ADDR_LSB-1:0];

    // Data is sampled in the cycle RD_LATENCY after the reg_rden cycle:
    // directly in ISSUE for zero latency, otherwise when the count reaches 1.
    assign capture = ((state == ISSUE) && (RD_LATENCY == 0)) ||
                     ((state == WAIT) && (cnt == 3'd1));

    // Read FSM with registered outputs; out-of-range reads walk the same
    // states so their latency matches, but never strobe the register file.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= 3'd0;
            in_range_q <= 1'b0;
            reg_rden   <= 1'b0;
            reg_rdaddr <= '0;
            rdata      <= '0;
            rresp      <= RESP_OKAY;
            rvalid     <= 1'b0;
        end else begin
            reg_rden <= 1'b0;
            case (state)
                IDLE: begin
                    if (ar_hs) begin
                        reg_rdaddr <= ar_word;
                        in_range_q <= ar_in_range;
                        reg_rden   <= ar_in_range;
                        state      <= ISSUE;
                    end
                end
                ISSUE: begin
                    cnt   <= LAT;
                    state <= (RD_LATENCY == 0) ? RESP : WAIT;
                end
                WAIT: begin
                    cnt <= cnt - 3'd1;
                    if (cnt == 3'd1) begin
                        state <= RESP;
                    end
                end
                RESP: begin
                    if (rready) begin
                        rvalid <= 1'b0;
                        state  <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
            if (capture) begin
                rdata  <= in_range_q ? reg_rddata : '0;
                rresp  <= in_range_q ? RESP_OKAY : RESP_SLVERR;
                rvalid <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi2reg_strb.sv
// AXI4-Lite slave to simple register-bus bridge with byte strobes,
// AW/W in either order, configurable read latency and SLVERR for
// word addresses beyond NUM_REGS.
module axi2reg_strb
    import axi2reg_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 6,
    parameter int DATA_WIDTH     = 32,
    parameter int NUM_REGS       = 16,
    parameter int RD_LATENCY     = 1,
    localparam int ADDR_LSB      = addr_lsb(DATA_WIDTH),
    localparam int RA_W          = AXI_ADDR_WIDTH - ADDR_LSB,
    localparam int STRB_W        = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst,
    axi2reg_strb_if.slave         s_axi,
    output logic                  reg_wren,
    output logic [RA_W-1:0]       reg_wraddr,
    output logic [DATA_WIDTH-1:0] reg_wrdata,
    output logic [STRB_W-1:0]     reg_wrstrb,
    output logic                  reg_rden,
    output logic [RA_W-1:0]       reg_rdaddr,
    input  logic [DATA_WIDTH-1:0] reg_rddata
);

    logic                      aw_full;
    logic                      w_full;
    logic [AXI_ADDR_WIDTH-1:0] aw_addr_q;
    logic [DATA_WIDTH-1:0]     w_data_q;
    logic [STRB_W-1:0]         w_strb_q;
    logic                      bvalid_q;
    logic [1:0]                bresp_q;
    logic                      aw_hs;
    logic                      w_hs;
    logic                      wr_fire;
    logic [AXI_ADDR_WIDTH-1:0] wr_addr_sel;
    logic [DATA_WIDTH-1:0]     wr_data_sel;
    logic [STRB_W-1:0]         wr_strb_sel;
    logic [RA_W-1:0]           wr_word;
    logic                      wr_in_range;
    rd_state_t                 rd_state;
    logic                      unused_bits;

    // Each holder takes one beat; both stay closed while a response waits.
    assign s_axi.awready = !aw_full && !bvalid_q;
    assign s_axi.wready  = !w_full && !bvalid_q;
    assign s_axi.bvalid  = bvalid_q;
    assign s_axi.bresp   = bresp_q;

    assign aw_hs = s_axi.awvalid && s_axi.awready;
    assign w_hs  = s_axi.wvalid && s_axi.wready;

    // The write issues on the edge where the second of AW/W arrives, so the
    // holder contents are bypassed with the live beat when it is not yet held.
    assign wr_fire     = (aw_full || aw_hs) && (w_full || w_hs);
    assign wr_addr_sel = aw_full ? aw_addr_q : s_axi.awaddr;
    assign wr_data_sel = w_full ? w_data_q : s_axi.wdata;
    assign wr_strb_sel = w_full ? w_strb_q : s_axi.wstrb;
    assign wr_word     = wr_addr_sel[AXI_ADDR_WIDTH-1:ADDR_LSB];
    assign wr_in_range = int'(wr_word) < NUM_REGS;

    assign unused_bits = ^{s_axi.awprot, s_axi.arprot,
                           wr_addr_sel[ADDR_LSB-1:0], rd_state};

    // Write holders, single-cycle register strobe and B response.
    always_ff @(posedge clk) begin
        if (rst) begin
            aw_full    <= 1'b0;
            w_full     <= 1'b0;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            bvalid_q   <= 1'b0;
            bresp_q    <= RESP_OKAY;
            reg_wren   <= 1'b0;
            reg_wraddr <= '0;
            reg_wrdata <= '0;
            reg_wrstrb <= '0;
        end else begin
            reg_wren <= 1'b0;
            if (wr_fire) begin
                aw_full    <= 1'b0;
                w_full     <= 1'b0;
                reg_wren   <= wr_in_range;
                reg_wraddr <= wr_word;
                reg_wrdata <= wr_data_sel;
                reg_wrstrb <= wr_strb_sel;
                bvalid_q   <= 1'b1;
                bresp_q    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_full   <= 1'b1;
                    aw_addr_q <= s_axi.awaddr;
                end
                if (w_hs) begin
                    w_full   <= 1'b1;
                    w_data_q <= s_axi.wdata;
                    w_strb_q <= s_axi.wstrb;
                end
                if (bvalid_q && s_axi.bready) begin
                    bvalid_q <= 1'b0;
                end
            end
        end
    end

    axi2reg_rd_ctrl #(
        .AXI_ADDR_WIDTH (AXI_ADDR_WIDTH),
        .DATA_WIDTH     (DATA_WIDTH),
        .NUM_REGS       (NUM_REGS),
        .RD_LATENCY     (RD_LATENCY)
    ) u_rd_ctrl (
        .clk        (clk),
        .rst        (rst),
        .araddr     (s_axi.araddr),
        .arvalid    (s_axi.arvalid),
        .arready    (s_axi.arready),
        .rdata      (s_axi.rdata),
        .rresp      (s_axi.rresp),
        .rvalid     (s_axi.rvalid),
        .rready     (s_axi.rready),
        .reg_rden   (reg_rden),
        .reg_rdaddr (reg_rdaddr),
        .reg_rddata (reg_rddata),
        .state      (rd_state)
    );

endmodule

// File: tb/tb_axi2reg_strb.sv
// Directed bench for axi2reg_strb with a byte-strobed register file model
// that returns read data two cycles after reg_rden.
module tb_axi2reg_strb;
    import axi2reg_pkg::*;

    localparam int AW      = 6;
    localparam int DW      = 32;
    localparam int SW      = 4;
    localparam int NR      = 12;
    localparam int LAT     = 2;
    localparam int RA_W    = 4;
    localparam int TIMEOUT = 50;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    axi2reg_strb_if #(.AXI_ADDR_WIDTH(AW), .DATA_WIDTH(DW)) s_axi ();

    logic            reg_wren;
    logic [RA_W-1:0] reg_wraddr;
    logic [DW-1:0]   reg_wrdata;
    logic [SW-1:0]   reg_wrstrb;
    logic            reg_rden;
    logic [RA_W-1:0] reg_rdaddr;
    logic [DW-1:0]   reg_rddata;

    axi2reg_strb #(
        .AXI_ADDR_WIDTH (AW),
        .DATA_WIDTH     (DW),
        .NUM_REGS       (NR),
        .RD_LATENCY     (LAT)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .s_axi      (s_axi),
        .reg_wren   (reg_wren),
        .reg_wraddr (reg_wraddr),
        .reg_wrdata (reg_wrdata),
        .reg_wrstrb (reg_wrstrb),
        .reg_rden   (reg_rden),
        .reg_rdaddr (reg_rdaddr),
        .reg_rddata (reg_rddata)
    );

    // ---------------- register file model ----------------
    logic [DW-1:0] regs [NR];
    logic [DW-1:0] rd_d1 = '0;
    logic [DW-1:0] rd_d2 = '0;

    initial for (int i = 0; i < NR; i++) regs[i] = '0;

    always @(posedge clk) begin
        if (reg_wren && int'(reg_wraddr) < NR) begin
            for (int b = 0; b < SW; b++)
                if (reg_wrstrb[b]) regs[reg_wraddr][8*b +: 8] <= reg_wrdata[8*b +: 8];
        end
        rd_d1 <= (int'(reg_rdaddr) < NR) ? regs[reg_rdaddr] : '0;
        rd_d2 <= rd_d1;
    end
    assign reg_rddata = rd_d2;

    // ---------------- strobe monitor ----------------
    int            wren_cnt = 0;
    int            rden_cnt = 0;
    int            wren_cyc = -1;
    logic [RA_W-1:0] last_wraddr = '0;
    logic [DW-1:0]   last_wrdata = '0;
    logic [SW-1:0]   last_wrstrb = '0;

    always @(negedge clk) begin
        if (reg_wren) begin
            wren_cnt    = wren_cnt + 1;
            wren_cyc    = cyc;
            last_wraddr = reg_wraddr;
            last_wrdata = reg_wrdata;
            last_wrstrb = reg_wrstrb;
        end
        if (reg_rden) rden_cnt = rden_cnt + 1;
    end

    int checks = 0;
    int fails  = 0;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        fails++;
        $display("FAIL %s: no handshake within %0d cycles", name, TIMEOUT);
    endtask

    task automatic send_aw(input logic [AW-1:0] a, output int post);
        int n = 0;
        s_axi.awaddr  = a;
        s_axi.awvalid = 1'b1;
        while (!s_axi.awready && n < TIMEOUT) begin tick(); n++; end
        tick();
        s_axi.awvalid = 1'b0;
        post = cyc;
        if (n >= TIMEOUT) timeout_fail("aw_timeout");
    endtask

    task automatic send_w(input logic [DW-1:0] d, input logic [SW-1:0] s, output int post);
        int n = 0;
        s_axi.wdata  = d;
        s_axi.wstrb  = s;
        s_axi.wvalid = 1'b1;
        while (!s_axi.wready && n < TIMEOUT) begin tick(); n++; end
        tick();
        s_axi.wvalid = 1'b0;
        post = cyc;
        if (n >= TIMEOUT) timeout_fail("w_timeout");
    endtask

    task automatic send_both(input logic [AW-1:0] a, input logic [DW-1:0] d,
                             input logic [SW-1:0] s);
        int   n = 0;
        logic aw_go, w_go;
        s_axi.awaddr  = a;
        s_axi.wdata   = d;
        s_axi.wstrb   = s;
        s_axi.awvalid = 1'b1;
        s_axi.wvalid  = 1'b1;
        while ((s_axi.awvalid || s_axi.wvalid) && n < TIMEOUT) begin
            aw_go = s_axi.awvalid && s_axi.awready;
            w_go  = s_axi.wvalid && s_axi.wready;
            tick();
            if (aw_go) s_axi.awvalid = 1'b0;
            if (w_go)  s_axi.wvalid  = 1'b0;
            n++;
        end
        if (n >= TIMEOUT) begin
            s_axi.awvalid = 1'b0;
            s_axi.wvalid  = 1'b0;
            timeout_fail("aw_w_timeout");
        end
    endtask

    task automatic wait_b(output logic [1:0] resp);
        int n = 0;
        while (!s_axi.bvalid && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("b_timeout");
        resp = s_axi.bresp;
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
    endtask

    task automatic send_ar(input logic [AW-1:0] a);
        int n = 0;
        s_axi.araddr  = a;
        s_axi.arvalid = 1'b1;
        while (!s_axi.arready && n < TIMEOUT) begin tick(); n++; end
        tick();
        s_axi.arvalid = 1'b0;
        if (n >= TIMEOUT) timeout_fail("ar_timeout");
    endtask

    // Called in the cycle after the AR handshake; lat counts cycles from it.
    task automatic wait_r(output logic [DW-1:0] d, output logic [1:0] resp, output int lat);
        lat = 1;
        while (!s_axi.rvalid && lat < TIMEOUT) begin tick(); lat++; end
        if (lat >= TIMEOUT) timeout_fail("r_timeout");
        d    = s_axi.rdata;
        resp = s_axi.rresp;
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                            input logic [SW-1:0] s, output logic [1:0] resp);
        send_both(a, d, s);
        wait_b(resp);
    endtask

    task automatic do_read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                           output logic [1:0] resp, output int lat);
        send_ar(a);
        wait_r(d, resp, lat);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        s_axi.awaddr = '0; s_axi.awprot = 3'b0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = 3'b0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        rst = 1'b1;
        repeat (3) tick();
        rst = 1'b0;
        tick();
        checks++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
            fails++;
            $display("FAIL reset_readies: got %b want 111",
                     {s_axi.awready, s_axi.wready, s_axi.arready});
        end
        checks++;
        if ({s_axi.bvalid, s_axi.rvalid, reg_wren, reg_rden} !== 4'b0000) begin
            fails++;
            $display("FAIL reset_valids: got %b want 0000",
                     {s_axi.bvalid, s_axi.rvalid, reg_wren, reg_rden});
        end
        checks++;
        if ({s_axi.bresp, s_axi.rresp, s_axi.rdata} !== 36'h0) begin
            fails++;
            $display("FAIL reset_payload: got bresp=%b rresp=%b rdata=%h want 0",
                     s_axi.bresp, s_axi.rresp, s_axi.rdata);
        end
    endtask

    logic [AW-1:0] t1_addr [4] = '{6'h00, 6'h04, 6'h08, 6'h2C};
    logic [DW-1:0] t1_data [4] = '{32'h33221100, 32'h77665544, 32'hBB998877, 32'hFFEEDDCC};

    task automatic test_write_read();
        logic [1:0]    resp;
        logic [DW-1:0] d;
        int            lat;
        wren_cnt = 0;
        for (int i = 0; i < 4; i++) begin
            do_write(t1_addr[i], t1_data[i], 4'hF, resp);
            checks++;
            if (resp !== RESP_OKAY) begin
                fails++;
                $display("FAIL wr_bresp[%0d]: got %b want 00", i, resp);
            end
        end
        checks++;
        if (wren_cnt !== 4) begin
            fails++;
            $display("FAIL wr_count: got %0d want 4", wren_cnt);
        end
        for (int i = 0; i < 4; i++) begin
            do_read(t1_addr[i], d, resp, lat);
            checks++;
            if (d !== t1_data[i] || resp !== RESP_OKAY || lat !== 4) begin
                fails++;
                $display("FAIL rd[%0d]: got data=%h resp=%b lat=%0d want data=%h resp=00 lat=4",
                         i, d, resp, lat, t1_data[i]);
            end
        end
    endtask

    task automatic test_split_order();
        logic [1:0] resp;
        int         post_aw, post_w;
        for (int k = 0; k < 2; k++) begin
            wren_cnt = 0;
            if (k == 0) begin
                send_aw(6'h10, post_aw);
                repeat (4) tick();
                send_w(32'hDEADBEEF, 4'hF, post_w);
            end else begin
                send_w(32'hDEADBEEF, 4'hF, post_aw);
                repeat (4) tick();
                send_aw(6'h10, post_w);
            end
            checks++;
            if (s_axi.bvalid !== 1'b1) begin
                fails++;
                $display("FAIL split%0d_bvalid: got %b want 1 in issue cycle", k, s_axi.bvalid);
            end
            wait_b(resp);
            checks++;
            if (wren_cnt !== 1 || wren_cyc !== post_w) begin
                fails++;
                $display("FAIL split%0d_wren: got count=%0d cycle=%0d want count=1 cycle=%0d",
                         k, wren_cnt, wren_cyc, post_w);
            end
            checks++;
            if (last_wraddr !== 4'd4 || last_wrdata !== 32'hDEADBEEF || resp !== RESP_OKAY) begin
                fails++;
                $display("FAIL split%0d_payload: got addr=%0d data=%h resp=%b want 4 deadbeef 00",
                         k, last_wraddr, last_wrdata, resp);
            end
        end
    endtask

    task automatic test_strobe();
        logic [1:0]    resp;
        logic [DW-1:0] d;
        int            lat;
        do_write(6'h14, 32'hFFFFFFFF, 4'hF, resp);
        do_write(6'h14, 32'h000000AA, 4'b0001, resp);
        checks++;
        if (last_wrstrb !== 4'b0001) begin
            fails++;
            $display("FAIL strb_pass: got %b want 0001", last_wrstrb);
        end
        wren_cnt = 0;
        do_write(6'h14, 32'h12345678, 4'b0000, resp);
        checks++;
        if (wren_cnt !== 1 || last_wrstrb !== 4'b0000 || resp !== RESP_OKAY) begin
            fails++;
            $display("FAIL strb_zero: got count=%0d strb=%b resp=%b want 1 0000 00",
                     wren_cnt, last_wrstrb, resp);
        end
        do_read(6'h14, d, resp, lat);
        checks++;
        if (d !== 32'hFFFFFFAA) begin
            fails++;
            $display("FAIL strb_merge: got %h want ffffffaa", d);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0]    resp;
        logic [DW-1:0] d;
        int            lat;
        wren_cnt = 0;
        do_write(6'h30, 32'h55555555, 4'hF, resp);
        checks++;
        if (resp !== RESP_SLVERR || wren_cnt !== 0) begin
            fails++;
            $display("FAIL oor_write: got resp=%b wren=%0d want 10 0", resp, wren_cnt);
        end
        rden_cnt = 0;
        do_read(6'h3C, d, resp, lat);
        checks++;
        if (d !== 32'h0 || resp !== RESP_SLVERR || lat !== 4 || rden_cnt !== 0) begin
            fails++;
            $display("FAIL oor_read: got data=%h resp=%b lat=%0d rden=%0d want 0 10 4 0",
                     d, resp, lat, rden_cnt);
        end
        do_read(6'h2D, d, resp, lat);
        checks++;
        if (d !== 32'hFFEEDDCC || resp !== RESP_OKAY) begin
            fails++;
            $display("FAIL unaligned_read: got data=%h resp=%b want ffeeddcc 00", d, resp);
        end
    endtask

    task automatic test_back_pressure();
        logic [1:0]    resp;
        logic [DW-1:0] d;
        int            lat, post, n;
        send_both(6'h18, 32'h0BADF00D, 4'hF);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({s_axi.bvalid, s_axi.bresp, s_axi.awready, s_axi.wready} !== 5'b1_00_00) begin
                fails++;
                $display("FAIL b_hold[%0d]: got bvalid=%b bresp=%b awready=%b wready=%b want 1 00 0 0",
                         i, s_axi.bvalid, s_axi.bresp, s_axi.awready, s_axi.wready);
            end
            if (i == 6) begin
                s_axi.awaddr  = 6'h1C;
                s_axi.awvalid = 1'b1;
            end
            tick();
        end
        s_axi.bready = 1'b1;
        tick();
        s_axi.bready = 1'b0;
        checks++;
        if (s_axi.awready !== 1'b1) begin
            fails++;
            $display("FAIL aw_after_b: got awready=%b want 1", s_axi.awready);
        end
        tick();
        s_axi.awvalid = 1'b0;
        send_w(32'h1C1C1C1C, 4'hF, post);
        wait_b(resp);
        do_read(6'h1C, d, resp, lat);
        checks++;
        if (d !== 32'h1C1C1C1C || resp !== RESP_OKAY) begin
            fails++;
            $display("FAIL queued_aw: got data=%h resp=%b want 1c1c1c1c 00", d, resp);
        end
        do_read(6'h18, d, resp, lat);
        checks++;
        if (d !== 32'h0BADF00D) begin
            fails++;
            $display("FAIL held_write: got %h want 0badf00d", d);
        end
        send_ar(6'h00);
        n = 0;
        while (!s_axi.rvalid && n < TIMEOUT) begin tick(); n++; end
        if (n >= TIMEOUT) timeout_fail("r_hold_timeout");
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({s_axi.rvalid, s_axi.rresp, s_axi.arready} !== 4'b1_00_0 ||
                s_axi.rdata !== 32'h33221100) begin
                fails++;
                $display("FAIL r_hold[%0d]: got rvalid=%b rresp=%b arready=%b rdata=%h want 1 00 0 33221100",
                         i, s_axi.rvalid, s_axi.rresp, s_axi.arready, s_axi.rdata);
            end
            tick();
        end
        s_axi.rready = 1'b1;
        tick();
        s_axi.rready = 1'b0;
        checks++;
        if (s_axi.arready !== 1'b1) begin
            fails++;
            $display("FAIL ar_after_r: got arready=%b want 1", s_axi.arready);
        end
    endtask

    task automatic test_reset_mid();
        logic [1:0]    resp;
        logic [DW-1:0] d;
        int            lat, post;
        logic          saw_rvalid;
        wren_cnt = 0;
        send_ar(6'h04);
        send_aw(6'h08, post);
        checks++;
        if (dut.u_rd_ctrl.state !== WAIT) begin
            fails++;
            $display("FAIL mid_state: got %0d want %0d (WAIT)", dut.u_rd_ctrl.state, WAIT);
        end
        rst = 1'b1;
        tick();
        rst = 1'b0;
        saw_rvalid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (s_axi.rvalid) saw_rvalid = 1'b1;
            tick();
        end
        checks++;
        if (saw_rvalid !== 1'b0 || wren_cnt !== 0) begin
            fails++;
            $display("FAIL mid_dropped: got rvalid_seen=%b wren=%0d want 0 0", saw_rvalid, wren_cnt);
        end
        checks++;
        if ({s_axi.awready, s_axi.wready, s_axi.arready} !== 3'b111) begin
            fails++;
            $display("FAIL mid_readies: got %b want 111",
                     {s_axi.awready, s_axi.wready, s_axi.arready});
        end
        do_write(6'h08, 32'h5A5AA5A5, 4'hF, resp);
        checks++;
        if (resp !== RESP_OKAY || wren_cnt !== 1) begin
            fails++;
            $display("FAIL mid_write: got resp=%b wren=%0d want 00 1", resp, wren_cnt);
        end
        do_read(6'h08, d, resp, lat);
        checks++;
        if (d !== 32'h5A5AA5A5 || resp !== RESP_OKAY || lat !== 4) begin
            fails++;
            $display("FAIL mid_read: got data=%h resp=%b lat=%0d want 5a5aa5a5 00 4", d, resp, lat);
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_split_order();
        test_strobe();
        test_out_of_range();
        test_back_pressure();
        test_reset_mid();
        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
